// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundling the redirect/stall inputs, the instruction-memory
// handshake and the valid-qualified output to decode.
// master = fetch stage, slave = environment (decode, branch unit, memory).
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_busy;
  logic        imem_done;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] PC_out;
  logic [15:0] next_PC_out;
  logic        valid;
  logic        halt;
  logic        err;
  modport master (
    input  stall, branch_taken, branch_target, imem_busy, imem_done, imem_data,
    output imem_rd, imem_addr, instruction, PC_out, next_PC_out, valid, halt, err
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_busy, imem_done, imem_data,
    input  imem_rd, imem_addr, instruction, PC_out, next_PC_out, valid, halt, err
  );
endinterface

// File: rtl/fetch.sv
// fetch: instruction-fetch stage with one outstanding memory read, one-entry skid buffer,
// redirect with late-data discard and HALT detection.
// Ports: clk, rst (sync, active high), f (fetch_if.master: stall/redirect in, imem handshake,
// instruction/PC_out/next_PC_out/valid/halt/err out).
// Optional: FETCH_ALIGN_CHK_EN enables odd-PC detection (sticky err, stage halts).
module fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master f
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d;
  logic [15:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic valid_q, valid_d, discard_q, discard_d;
  logic free, misalign, lock, accept;
`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;
  assign misalign = pc_q[0];
  assign lock = err_q;
  assign f.err = err_q;
  assign err_d = err_q | (state_q == FETCH && misalign && !f.branch_taken);
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
`else
  assign misalign = 1'b0;
  assign lock = 1'b0;
  assign f.err = 1'b0;
`endif
  assign free = !valid_q || !f.stall;
  assign f.imem_rd = state_q == FETCH && !misalign;
  assign f.imem_addr = pc_q;
  assign accept = f.imem_rd && !f.imem_busy;
  assign f.instruction = instr_q;
  assign f.PC_out = pc_out_q;
  assign f.next_PC_out = pc_out_q + 16'd2;
  assign f.valid = valid_q;
  assign f.halt = state_q == HALTED;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    pc_out_d = pc_out_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    valid_d = valid_q;
    discard_d = discard_q;
    if (valid_q && !f.stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
    case (state_q)
      FETCH:
        if (misalign) begin
          state_d = HALTED;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!f.imem_busy) state_d = WAIT;
      WAIT:
        if (f.imem_done && discard_q) begin
          discard_d = 1'b0;
          state_d = FETCH;
        end else if (f.imem_done) begin
          pc_d = pc_q + 16'd2;
          if (free) begin
            instr_d = f.imem_data;
            pc_out_d = pc_q;
            valid_d = 1'b1;
            state_d = f.imem_data[15:11] == 5'd0 ? HALTED : FETCH;
          end else begin
            skid_instr_d = f.imem_data;
            skid_pc_d = pc_q;
            state_d = HOLD;
          end
        end
      HOLD:
        if (!f.stall) begin
          instr_d = skid_instr_q;
          pc_out_d = skid_pc_q;
          valid_d = 1'b1;
          state_d = skid_instr_q[15:11] == 5'd0 ? HALTED : FETCH;
        end
      default: ;
    endcase
    // A request the memory has taken (still in flight, or accepted on this very edge)
    // must have its data dropped before a new request may go out.
    if (f.branch_taken && !lock) begin
      pc_d = f.branch_target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      skid_instr_d = NOP_INSTR;
      skid_pc_d = RESET_PC;
      if ((state_q == WAIT && !f.imem_done) || accept) begin
        discard_d = 1'b1;
        state_d = WAIT;
      end else begin
        discard_d = 1'b0;
        state_d = FETCH;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q <= RESET_PC;
      valid_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc_out_q <= pc_out_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
      valid_q <= valid_d;
      discard_q <= discard_d;
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed and randomized checks of fetch against a program-stream reference model.
module tb_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if bus();
  fetch dut (.clk(clk), .rst(rst), .f(bus));
  logic s_stall = 1'b0, s_br = 1'b0;
  logic [15:0] s_tgt = 16'h0;
  logic m_busy = 1'b1, m_done = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic r_busy = 1'b0, r_done = 1'b0;
  logic [15:0] r_data = 16'h0;
  bit auto = 1'b1, nobusy = 1'b1, proto_bad = 1'b0;
  int lat_cfg = 1;
  assign bus.stall = s_stall;
  assign bus.branch_taken = s_br;
  assign bus.branch_target = s_tgt;
  assign bus.imem_busy = auto ? r_busy : m_busy;
  assign bus.imem_done = auto ? r_done : m_done;
  assign bus.imem_data = auto ? r_data : m_data;
  logic [15:0] prog [0:255];
  int vecs = 0, errs = 0;
  logic [15:0] exp_pc = 16'h0, req_exp = 16'h0;
  bit stopped = 1'b0;
  function automatic logic [15:0] word(input logic [15:0] a);
    return prog[a[8:1]];
  endfunction
  function automatic logic is_halt(input logic [15:0] w);
    return w[15:11] == 5'd0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Memory: accepts a read when imem_rd && !imem_busy, answers after a latency of cycles.
  bit pending = 1'b0;
  int cnt = 0;
  logic [15:0] p_addr = 16'h0;
  initial forever begin
    @(negedge clk);
    if (rst || !auto) begin
      pending = 1'b0;
      r_done = 1'b0;
      r_busy = 1'b0;
    end else begin
      r_done = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          r_done = 1'b1;
          r_data = word(p_addr);
          pending = 1'b0;
        end
      end
      r_busy = !nobusy && $urandom_range(0, 3) == 0;
      if (bus.imem_rd) begin
        if (pending || r_done) proto_bad = 1'b1;
        if (!r_busy) begin
          pending = 1'b1;
          p_addr = bus.imem_addr;
          cnt = lat_cfg == 0 ? int'($urandom_range(1, 4)) : lat_cfg;
        end
      end
    end
  end
  task automatic check_outputs();
    if (stopped) chk("halted_idle", {bus.halt, bus.imem_rd, bus.valid}, 3'b100);
    else if (bus.valid) begin
      chk("pc_out", bus.PC_out, exp_pc);
      chk("instr", bus.instruction, word(exp_pc));
      chk("next_pc", bus.next_PC_out, 16'(exp_pc + 16'd2));
      if (bus.halt) chk("halt_word", is_halt(bus.instruction), 1'b1);
    end else chk("nop_halt", {bus.instruction, bus.halt}, {16'h0800, 1'b0});
    if (!bus.valid) chk("nop", bus.instruction, 16'h0800);
    chk("err", bus.err, 1'b0);
  endtask
  // Drive one cycle's inputs, advance the stream model, then check the next cycle.
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    s_stall = s;
    s_br = b;
    s_tgt = t;
    if (bus.imem_rd && !bus.imem_busy && !b) begin
      chk("req_addr", bus.imem_addr, req_exp);
      req_exp += 16'd2;
    end
    if (bus.valid && !s) begin
      if (is_halt(word(exp_pc))) stopped = 1'b1;
      exp_pc += 16'd2;
    end
    if (b) begin
      exp_pc = t;
      req_exp = t;
      stopped = 1'b0;
    end
    @(negedge clk);
    #1;
    s_br = 1'b0;
    check_outputs();
  endtask
  task automatic redirect(input logic [15:0] t);
    for (int n = 0; n < 8 && bus.imem_rd && !bus.imem_busy; n++) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, t);
  endtask
  initial begin
    logic [15:0] w;
    logic [9:0] vt;
    int n, rdc;
    bit sawv;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (is_halt(w)) w[15] = 1'b1;
      if ($urandom_range(0, 19) == 0) w[15:11] = 5'd0;
      prog[i] = w;
    end
    prog[0] = 16'h4000; prog[1] = 16'h4001; prog[2] = 16'h0000;
    prog[8] = 16'h1111; prog[9] = 16'h2222; prog[10] = 16'h3333; prog[11] = 16'h0000;
    prog[255] = 16'h0800;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out", {bus.instruction, bus.PC_out, bus.next_PC_out}, {16'h0800, 16'h0000, 16'h0002});
    chk("rst_flags", {bus.valid, bus.halt, bus.err, bus.imem_rd}, 4'b0001);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    // three words with a 1-cycle memory: valid every other cycle, halt after the third
    vt[0] = bus.valid;
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0);
      vt[i] = bus.valid;
    end
    chk("valid_trace", vt, 10'b0001010100);
    chk("halt_final", {bus.halt, bus.imem_rd}, 2'b10);
    // stall held while a word returns: it waits in the skid buffer
    redirect(16'h0010);
    for (n = 0; n < 10 && !bus.valid; n++) step(1'b0, 1'b0, 16'h0);
    chk("wait_valid1", bus.valid, 1'b1);
    rdc = 0;
    repeat (4) begin
      step(1'b1, 1'b0, 16'h0);
      rdc += int'(bus.imem_rd);
    end
    chk("stall_no_rd", rdc, 0);
    chk("stall_hold_pc", bus.PC_out, 16'h0010);
    step(1'b0, 1'b0, 16'h0);
    chk("skid_out", {bus.valid, bus.PC_out}, {1'b1, 16'h0012});
    // redirect while a 3-cycle read is in flight: late word dropped
    lat_cfg = 3;
    redirect(16'h0030);
    for (n = 0; n < 8 && !(bus.imem_rd && !bus.imem_busy); n++) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0100);
    sawv = 1'b0;
    for (n = 0; n < 10 && !bus.imem_rd; n++) begin
      sawv |= bus.valid;
      step(1'b0, 1'b0, 16'h0);
    end
    chk("discard_wait", n, 2);
    chk("discard_nov", sawv, 1'b0);
    chk("redir_addr", {bus.imem_rd, bus.imem_addr}, {1'b1, 16'h0100});
    // redirect in the same cycle as imem_done
    lat_cfg = 1;
    step(1'b0, 1'b0, 16'h0);
    for (n = 0; n < 6 && !bus.imem_done; n++) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0200);
    chk("br_done", {bus.imem_rd, bus.valid, bus.imem_addr}, {2'b10, 16'h0200});
    // PC wrap at 0xFFFE
    redirect(16'hFFFE);
    for (n = 0; n < 10 && !bus.valid; n++) step(1'b0, 1'b0, 16'h0);
    chk("wrap_pc", {bus.valid, bus.PC_out, bus.next_PC_out}, {1'b1, 16'hFFFE, 16'h0000});
    chk("wrap_addr", {bus.imem_rd, bus.imem_addr}, {1'b1, 16'h0000});
    // randomized stalls, redirects, latencies and busy
    nobusy = 1'b0;
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s, b;
      s = $urandom_range(0, 2) == 0;
      b = stopped ? $urandom_range(0, 3) == 0 : $urandom_range(0, 39) == 0;
      if (bus.imem_rd && !bus.imem_busy) b = 1'b0;
      step(s, b, 16'($urandom_range(0, 255)) << 1);
    end
    // reset mid-request, then a stray imem_done must be ignored
    nobusy = 1'b1;
    lat_cfg = 3;
    redirect(16'h0020);
    for (n = 0; n < 8 && !(bus.imem_rd && !bus.imem_busy); n++) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    auto = 1'b0;
    m_busy = 1'b1;
    m_done = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst", {bus.valid, bus.halt, bus.imem_rd, bus.imem_addr}, {3'b001, 16'h0000});
    m_done = 1'b1;
    m_data = 16'h0000;
    @(negedge clk);
    #1 m_done = 1'b0;
    chk("stray_done", {bus.valid, bus.halt, bus.instruction}, {2'b00, 16'h0800});
    @(posedge clk);
    #1 auto = 1'b1;
    lat_cfg = 1;
    @(negedge clk);
    #1;
    exp_pc = 16'h0;
    req_exp = 16'h0;
    stopped = 1'b0;
    repeat (10) step(1'b0, 1'b0, 16'h0);
    chk("post_rst_halt", bus.halt, 1'b1);
    // odd redirect target
    redirect(16'h0101);
`ifdef FETCH_ALIGN_CHK_EN
    chk("odd_no_rd", bus.imem_rd, 1'b0);
    @(negedge clk);
    #1;
    chk("odd_err", {bus.err, bus.halt, bus.valid}, 3'b110);
    s_br = 1'b1;
    s_tgt = 16'h0040;
    @(negedge clk);
    #1 s_br = 1'b0;
    chk("odd_locked", {bus.err, bus.halt, bus.imem_rd}, 3'b110);
`else
    chk("odd_addr", {bus.imem_rd, bus.err, bus.imem_addr}, {2'b10, 16'h0101});
    repeat (6) step(1'b0, 1'b0, 16'h0);
`endif
    chk("one_outstanding", proto_bad, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
